// File: rtl/reg_reduce_gate.sv
// reg_reduce_gate: pipelined run-time selectable reduction gate with valid tracking and zero-result counter
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   en               advance enable; 0 stalls every register
//   in_data/in_valid operand vector and its valid flag, captured when en=1
//   mode             00 NAND, 01 AND, 10 NOR, 11 OR (captured with in_data)
//   clr_count        synchronous clear of low_count, independent of en
//   out_data/out_valid  result after STAGES enabled edges; out_data is 0 on bubbles
//   low_count        saturating count of delivered zero results
module reg_reduce_gate #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic             clr_count,
    output logic             out_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] low_count
);
    logic [WIDTH-1:0] data1;
    logic             valid1;
    logic [1:0]       mode1;
    logic             res1;
    logic             zero_del;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data1  <= '0;
            valid1 <= 1'b0;
            mode1  <= 2'b00;
        end else if (en) begin
            data1  <= in_data;
            valid1 <= in_valid;
            mode1  <= mode;
        end
    end

    // mode1[1] picks OR over AND, mode1[0]=0 inverts; bubbles are zeroed here so later stages need no gating
    assign res1 = valid1 & ((mode1[1] ? |data1 : &data1) ~^ mode1[0]);

    generate
        if (STAGES == 1) begin : g_direct
            assign out_data  = res1;
            assign out_valid = valid1;
        end else begin : g_pipe
            logic [STAGES-2:0] rdat;
            logic [STAGES-2:0] rval;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdat <= '0;
                    rval <= '0;
                end else if (en) begin
                    rdat[0] <= res1;
                    rval[0] <= valid1;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        rdat[i] <= rdat[i-1];
                        rval[i] <= rval[i-1];
                    end
                end
            end
            assign out_data  = rdat[STAGES-2];
            assign out_valid = rval[STAGES-2];
        end
    endgenerate

    // a stalled output is delivered only on the enabled edge that moves it on
    assign zero_del = en & out_valid & ~out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            low_count <= '0;
        else if (clr_count)
            low_count <= '0;
        else if (zero_del && low_count != '1)
            low_count <= low_count + CNT_W'(1);
    end
endmodule
